// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - multi-cycle adder/subtractor time-sharing one 4-bit ripple-carry stage
// One nibble per clock, LSB first; the carry between nibbles lives in c_q.

module rca4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic [4:0] c;

   assign c[0] = c_i;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = c[4];
endmodule

module nibble_add_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             ovfl
);
   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             ovfl_q;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       sum_d;
   logic             carry_d;

   assign a_nib = a_q[{cnt_q, 2'b00} +: 4];
   assign b_nib = b_q[{cnt_q, 2'b00} +: 4];

   rca4 u_rca4 (
      .a_i (a_nib),
      .b_i (b_nib),
      .c_i (c_q),
      .s_o (sum_d),
      .c_o (carry_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovfl_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
               if (start) begin
                  a_q     <= A;
                  b_q     <= sub ? ~B : B;
                  c_q     <= sub;
                  cnt_q   <= '0;
                  s_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               s_q[{cnt_q, 2'b00} +: 4] <= sum_d;
               c_q   <= carry_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cout_q  <= carry_d;
                  ovfl_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[3] != a_q[WIDTH-1]);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign Cout = cout_q;
   assign ovfl = ovfl_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - directed self-checking bench for nibble_add_seq (WIDTH=16)

module tb_nibble_add_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sub;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] S;
   logic        Cout;
   logic        ovfl;

   int checks = 0;
   int errors = 0;

   nibble_add_seq #(.WIDTH(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .sub  (sub),
      .A    (A),
      .B    (B),
      .busy (busy),
      .done (done),
      .S    (S),
      .Cout (Cout),
      .ovfl (ovfl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start one op at a negedge; expect 4 busy cycles then a done cycle with the result.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] exp_s, input logic exp_c, input logic exp_v);
      A = a; B = b; sub = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = 16'h0; B = 16'h0; sub = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("S", S, exp_s);
      chk("Cout", Cout, exp_c);
      chk("ovfl", ovfl, exp_v);
      @(negedge clk);
      chk("done_drop", done, 0);
      chk("S_hold", S, exp_s);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; A = 16'h0; B = 16'h0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_S", S, 0);
      chk("rst_Cout", Cout, 0);
      chk("rst_ovfl", ovfl, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Reset after two nibbles: outputs clear asynchronously, no done.
      A = 16'h1234; B = 16'h4321; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_S", S, 0);
      chk("arst_Cout", Cout, 0);
      chk("arst_ovfl", ovfl, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

      // start held high: a new op is accepted in each DONE cycle.
      A = 16'h7FFF; B = 16'h0001; sub = 1'b0; start = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         chk("hold_done", done, (i % 5 == 0) ? 1 : 0);
         chk("hold_busy", busy, (i % 5 == 0) ? 0 : 1);
         if (i % 5 == 0) begin
            chk("hold_S", S, 16'h8000);
            chk("hold_ovfl", ovfl, 1);
            chk("hold_Cout", Cout, 0);
         end
         if (i == 14) start = 1'b0;
      end
      @(negedge clk);
      chk("hold_end_busy", busy, 0);
      chk("hold_end_done", done, 0);

      // start pulsed mid-RUN with new operands: ignored.
      A = 16'h1234; B = 16'h4321; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 16'hAAAA; B = 16'h5555; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("ign_busy", busy, 1);
      @(negedge clk);
      chk("ign_done", done, 1);
      chk("ign_S", S, 16'h5555);
      chk("ign_Cout", Cout, 0);
      chk("ign_ovfl", ovfl, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("ign_no_extra_done", done, 0);
         chk("ign_idle_busy", busy, 0);
      end
      chk("ign_S_hold", S, 16'h5555);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
